// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: requests a word from instruction memory at the PC,
// waits for the acknowledge (bounded by TMO cycles), then issues it downstream.
module instr_fetch_unit #(
    parameter int I   = 32,
    parameter int N   = 8,
    parameter int TMO = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [I-1:0] PCNext,
    input  logic         EndFlag,
    input  logic         stall,
    output logic         imem_req,
    output logic [I-1:0] imem_addr,
    input  logic [I-1:0] imem_rdata,
    input  logic         imem_ack,
    output logic [I-1:0] Instr,
    output logic [3:0]   Id,
    output logic [N-1:0] Imm,
    output logic [I-1:0] FetchPC,
    output logic         instr_valid,
    output logic         pc_en,
    output logic         Halted,
    output logic         FetchErr
);

    localparam int CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ISSUE,
        HALT,
        ERR
    } state_t;

    state_t         state_q, state_d;
    logic [I-1:0]   addr_q, addr_d;
    logic [I-1:0]   instr_q, instr_d;
    logic [I-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           halted_q, halted_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            instr_q    <= '0;
            fetch_pc_q <= '0;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        fetch_pc_d  = fetch_pc_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        err_d       = err_q;
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        pc_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = PCNext;
                addr_d    = PCNext;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // Start is deliberately ignored here: the request in flight always completes.
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    fetch_pc_d = addr_q;
                    state_d    = ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(TMO)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    if (EndFlag) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = start ? REQ : IDLE;
                    end
                end
            end
            HALT: begin
            end
            ERR: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Instr    = instr_q;
    assign FetchPC  = fetch_pc_q;
    assign Id       = instr_q[I-1 -: 4];
    assign Imm      = instr_q[N-1:0];
    assign Halted   = halted_q;
    assign FetchErr = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetched words are queued as expectations
// when the acknowledge is driven and checked when the unit issues them.
module tb_instr_fetch_unit;

    localparam int I   = 32;
    localparam int N   = 8;
    localparam int TMO = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [I-1:0] PCNext = '0;
    logic         EndFlag = 1'b0;
    logic         stall = 1'b0;
    logic         imem_req;
    logic [I-1:0] imem_addr;
    logic [I-1:0] imem_rdata = '0;
    logic         imem_ack = 1'b0;
    logic [I-1:0] Instr;
    logic [3:0]   Id;
    logic [N-1:0] Imm;
    logic [I-1:0] FetchPC;
    logic         instr_valid;
    logic         pc_en;
    logic         Halted;
    logic         FetchErr;

    instr_fetch_unit #(.I(I), .N(N), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .PCNext     (PCNext),
        .EndFlag    (EndFlag),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .Instr      (Instr),
        .Id         (Id),
        .Imm        (Imm),
        .FetchPC    (FetchPC),
        .instr_valid(instr_valid),
        .pc_en      (pc_en),
        .Halted     (Halted),
        .FetchErr   (FetchErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [I-1:0] instr;
        logic [I-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pc_en_cnt = 0;
    int   req_cnt = 0;

    always @(negedge clk) begin
        if (pc_en)    pc_en_cnt++;
        if (imem_req) req_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one fetch: REQ, then d WAIT cycles with the ack in the last one; returns in ISSUE.
    task automatic fetch(input logic [I-1:0] pc, input logic [I-1:0] data, input int d);
        int   req0;
        exp_t e;
        PCNext = pc;
        start  = 1'b1;
        #1;
        for (int i = 0; i < 4 && !imem_req; i++) begin
            cyc();
            #1;
        end
        chk("req_seen", imem_req, 1);
        chk("req_addr", imem_addr, pc);
        req0 = req_cnt;
        for (int k = 1; k <= d; k++) begin
            cyc();
            PCNext = ~pc;
            if (k == d) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
                e.instr    = data;
                e.pc       = pc;
                sb.push_back(e);
            end
            #1;
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, pc);
        end
        cyc();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("req_cycles", req_cnt - req0, d + 1);
    endtask

    // Holds stall for the given cycles, then completes the ISSUE handshake.
    task automatic issue(input int stalls, input logic endf, input logic start_after);
        exp_t e;
        int   p0;
        p0 = pc_en_cnt;
        chk("issue_valid", instr_valid, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        for (int s = 0; s < stalls; s++) begin
            stall   = 1'b1;
            EndFlag = endf;
            #1;
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", Instr, e.instr);
            chk("stall_fpc", FetchPC, e.pc);
            chk("stall_pcen", pc_en, 0);
            chk("stall_halted", Halted, 0);
            cyc();
        end
        stall   = 1'b0;
        EndFlag = endf;
        start   = start_after;
        #1;
        chk("issue_instr", Instr, e.instr);
        chk("issue_fpc", FetchPC, e.pc);
        chk("issue_id", Id, e.instr[31:28]);
        chk("issue_imm", Imm, e.instr[7:0]);
        chk("issue_pcen", pc_en, !endf);
        cyc();
        EndFlag = 1'b0;
        chk("pcen_pulses", pc_en_cnt - p0, endf ? 0 : 1);
    endtask

    initial begin
        int r0;

        // Reset state
        repeat (2) cyc();
        chk("rst_instr", Instr, 0);
        chk("rst_fpc", FetchPC, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_pcen", pc_en, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_err", FetchErr, 0);
        reset = 1'b0;
        PCNext = 32'h40;
        repeat (3) begin
            cyc();
            chk("idle_noreq", imem_req, 0);
        end

        // Basic fetch with immediate ack
        fetch(32'h0, 32'hC000_0010, 1);
        chk("first_id", Id, 4'hC);
        chk("first_imm", Imm, 8'h10);
        chk("first_fpc", FetchPC, 0);
        issue(0, 1'b0, 1'b1);

        // Delayed ack, then stalled issue
        fetch(32'h100, 32'hA5A5_1234, 5);
        issue(0, 1'b0, 1'b1);
        fetch(32'h104, 32'h1234_5678, 2);
        issue(4, 1'b0, 1'b1);

        // Reset in the middle of WAIT
        PCNext = 32'h200;
        #1;
        for (int i = 0; i < 4 && !imem_req; i++) begin
            cyc();
            #1;
        end
        cyc();
        chk("mid_wait_req", imem_req, 1);
        reset = 1'b1;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_instr", Instr, 0);
        chk("arst_fpc", FetchPC, 0);
        chk("arst_pcen", pc_en, 0);
        start = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("post_rst_noreq", imem_req, 0);
        fetch(32'h300, 32'h0BAD_F00D, 1);
        issue(0, 1'b0, 1'b0);
        chk("back_idle", imem_req, 0);
        cyc();
        chk("stay_idle", imem_req, 0);

        // END instruction with coincident stall
        fetch(32'h400, 32'hF000_0000, 1);
        issue(2, 1'b1, 1'b1);
        chk("halt_set", Halted, 1);
        chk("halt_valid", instr_valid, 0);
        r0 = req_cnt;
        for (int c = 0; c < 20; c++) begin
            imem_ack   = (c == 3);
            imem_rdata = 32'h7777_7777;
            cyc();
        end
        imem_ack = 1'b0;
        chk("halt_noreq", req_cnt - r0, 0);
        chk("halt_sticky", Halted, 1);
        chk("halt_instr", Instr, 32'hF000_0000);

        // Acknowledge timeout
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_clr_halt", Halted, 0);
        PCNext = 32'h500;
        start  = 1'b1;
        #1;
        for (int i = 0; i < 4 && !imem_req; i++) begin
            cyc();
            #1;
        end
        chk("to_req_seen", imem_req, 1);
        r0 = req_cnt;
        for (int k = 1; k <= TMO; k++) begin
            cyc();
            chk("to_wait_req", imem_req, 1);
            chk("to_wait_err", FetchErr, 0);
        end
        cyc();
        chk("to_err", FetchErr, 1);
        chk("to_req_low", imem_req, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        cyc();
        imem_ack = 1'b0;
        chk("to_late_valid", instr_valid, 0);
        chk("to_late_instr", Instr, 0);
        repeat (5) cyc();
        chk("to_req_total", req_cnt - r0, TMO + 1);
        chk("to_err_sticky", FetchErr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter I, default 32, instruction and address width.
REQ-002 Parameter N, default 8, immediate width.
REQ-003 Parameter TMO, default 15, maximum wait cycles for a memory acknowledge before flagging an error.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; fetching is permitted only while high.
REQ-007 PCNext  input  I  current PC from the PC control unit.
REQ-008 EndFlag  input  1  END instruction currently decoded.
REQ-009 stall  input  1  downstream not ready to accept an instruction.
REQ-010 imem_req  output  1  instruction-memory read request.
REQ-011 imem_addr  output  I  instruction-memory read address.
REQ-012 imem_rdata  input  I  instruction-memory read data, valid with imem_ack.
REQ-013 imem_ack  input  1  one-cycle read acknowledge.
REQ-014 Instr  output  I  registered fetched instruction.
REQ-015 Id  output  4  Instr[I-1:I-4].
REQ-016 Imm  output  N  Instr[N-1:0].
REQ-017 FetchPC  output  I  address Instr was fetched from.
REQ-018 instr_valid  output  1  Instr/Id/Imm/FetchPC are valid this cycle.
REQ-019 pc_en  output  1  one-cycle pulse allowing the PC register to advance.
REQ-020 Halted  output  1  sticky; END has been reached.
REQ-021 FetchErr  output  1  sticky; acknowledge timeout occurred.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT, ISSUE, HALT and ERR.
REQ-023 IDLE: all outputs low; go to REQ when start=1.
REQ-024 REQ: imem_req=1 and imem_addr=PCNext for exactly one cycle; latch PCNext into an internal address register; go to WAIT.
REQ-025 WAIT: hold imem_req=1 with imem_addr=latched address.
  - On imem_ack=1: capture imem_rdata into Instr and the address into FetchPC; go to ISSUE.
  - Otherwise: increment the wait counter.
REQ-026 If the wait counter reaches TMO without imem_ack, the FSM SHALL go to ERR and set FetchErr.
REQ-027 The wait counter SHALL clear on entry to WAIT and be sized to ceil(log2(TMO+1)) bits with no wrap.
REQ-028 ISSUE: instr_valid=1; Instr and FetchPC are held stable while stall=1.
REQ-029 ISSUE with stall=0 and EndFlag=0: pulse pc_en for that single cycle; go to REQ.
REQ-030 ISSUE with stall=0 and EndFlag=1: no pc_en; set Halted; go to HALT.
REQ-031 HALT and ERR SHALL be absorbing states with instr_valid=0, imem_req=0 and pc_en=0; only reset exits them.
REQ-032 If start falls in REQ or WAIT, the outstanding request SHALL complete (ack or timeout) before returning to IDLE; in ISSUE, start=0 returns to IDLE after the handshake (stall=0).
REQ-033 An imem_ack arriving outside WAIT SHALL be ignored.
REQ-034 Minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT with immediate ack, ISSUE).
REQ-035 Id and Imm SHALL be combinational slices of the registered Instr.
REQ-036 Simultaneous EndFlag=1 and stall=1 in ISSUE SHALL wait; Halted sets only when stall=0.

Reset
REQ-037 Asserting reset at any time, including mid-WAIT, SHALL immediately force IDLE and clear to 0: Instr, FetchPC, counter, instr_valid, imem_req, pc_en, Halted, FetchErr.
REQ-038 After reset deasserts, no request SHALL issue before the first clock edge with start=1.

Verification
REQ-039 start=1, PCNext=0x0, ack in the first WAIT cycle with rdata=0xC0000010 -> instr_valid next cycle, Id=0xC, Imm=0x10, FetchPC=0, one pc_en pulse.
REQ-040 Ack delayed 5 cycles -> imem_req held 6 cycles with a constant imem_addr; Instr matches rdata at the ack.
REQ-041 No ack for TMO=15 cycles -> FetchErr=1, imem_req=0 thereafter; a later ack is ignored.
REQ-042 stall=1 for 4 cycles in ISSUE -> Instr stable and no pc_en until stall=0, then exactly one pc_en.
REQ-043 EndFlag=1 in ISSUE -> Halted=1, no pc_en, no further imem_req for 20 cycles.
REQ-044 Reset pulsed mid-WAIT -> all outputs 0 asynchronously; refetch from PCNext after start.
